// File: rtl/spi_queue.sv
// Buffered front end for the SPI engine: TX FIFO feeding a launch FSM, received frames into an RX FIFO.
// Every output is a register; flags, busy and rx_data are loaded from next-state values.
module spi_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_width_16,
  input  logic        tx_push,
  input  logic        rx_enable,
  input  logic        rx_pop,
  input  logic        clear_flags,
  output logic [15:0] rx_data,
  output logic [4:0]  tx_count,
  output logic [4:0]  rx_count,
  output logic        tx_full,
  output logic        tx_empty,
  output logic        rx_full,
  output logic        rx_empty,
  output logic        tx_overflow,
  output logic        busy,
  output logic        spi_start,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic        spi_busy,
  input  logic [15:0] spi_data_rx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN, CAPTURE} state_t;
  state_t state, state_next;

  logic [16:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd, rx_rd_next;
  logic [4:0]    tx_count_next, rx_count_next;
  logic [15:0]   rx_wdata, rx_head_next;
  logic          keep, launch, tx_wen, tx_ren, rx_wen, rx_ren;

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    tx_ren     = 1'b0;
    rx_wen     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && !rx_full && !spi_busy) begin
          state_next = START;
          launch     = 1'b1;
        end
      end
      START: begin
        if (spi_busy) begin
          state_next = RUN;
          tx_ren     = 1'b1;
        end
      end
      RUN: begin
        if (!spi_busy) state_next = CAPTURE;
      end
      CAPTURE: begin
        rx_wen     = keep;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_wen        = tx_push && (tx_count < FULL_CNT);
    rx_ren        = rx_pop && (rx_count != '0);
    tx_count_next = tx_count + 5'(tx_wen) - 5'(tx_ren);
    rx_count_next = rx_count + 5'(rx_wen) - 5'(rx_ren);
    rx_rd_next    = rx_ren ? rx_rd + AW'(1) : rx_rd;
    rx_wdata      = spi_width_16 ? spi_data_rx : {8'h00, spi_data_rx[7:0]};
    // A write landing on the new head slot is not in rx_mem yet, so forward it.
    if (rx_count_next == '0)
      rx_head_next = '0;
    else if (rx_wen && (rx_wr == rx_rd_next))
      rx_head_next = rx_wdata;
    else
      rx_head_next = rx_mem[rx_rd_next];
  end

  always_ff @(posedge raw_clk) begin
    if (tx_wen) tx_mem[tx_wr] <= {tx_width_16, tx_data};
    if (rx_wen) rx_mem[rx_wr] <= rx_wdata;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      tx_count     <= '0;
      rx_count     <= '0;
      tx_full      <= 1'b0;
      tx_empty     <= 1'b1;
      rx_full      <= 1'b0;
      rx_empty     <= 1'b1;
      tx_overflow  <= 1'b0;
      busy         <= 1'b0;
      spi_start    <= 1'b0;
      spi_width_16 <= 1'b0;
      spi_data_tx  <= '0;
      rx_data      <= '0;
      keep         <= 1'b0;
    end else begin
      state    <= state_next;
      if (tx_wen) tx_wr <= tx_wr + AW'(1);
      if (tx_ren) tx_rd <= tx_rd + AW'(1);
      if (rx_wen) rx_wr <= rx_wr + AW'(1);
      rx_rd    <= rx_rd_next;
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
      tx_full  <= (tx_count_next == FULL_CNT);
      tx_empty <= (tx_count_next == '0);
      rx_full  <= (rx_count_next == FULL_CNT);
      rx_empty <= (rx_count_next == '0);
      if (tx_push && !tx_wen)
        tx_overflow <= 1'b1;
      else if (clear_flags)
        tx_overflow <= 1'b0;
      busy      <= (state_next != IDLE) || (tx_count_next != '0);
      spi_start <= (state_next == START);
      if (launch) begin
        {spi_width_16, spi_data_tx} <= tx_mem[tx_rd];
        keep <= rx_enable;
      end
      rx_data <= rx_head_next;
    end
  end

endmodule

// File: tb/tb_spi_queue.sv
// Self-checking bench for spi_queue: engine model, frame table, directed corner sequences, random bursts.
module tb_spi_queue;

  localparam int unsigned DEPTH = 8;

  logic        raw_clk = 1'b0;
  logic        reset, tx_width_16, tx_push, rx_enable, rx_pop, clear_flags;
  logic [15:0] tx_data, rx_data, spi_data_tx, spi_data_rx;
  logic [4:0]  tx_count, rx_count;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_overflow, busy;
  logic        spi_start, spi_width_16, spi_busy;

  always #5 raw_clk = ~raw_clk;

  spi_queue #(.DEPTH(DEPTH)) dut (
    .raw_clk(raw_clk), .reset(reset), .tx_data(tx_data), .tx_width_16(tx_width_16),
    .tx_push(tx_push), .rx_enable(rx_enable), .rx_pop(rx_pop), .clear_flags(clear_flags),
    .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count), .tx_full(tx_full),
    .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty), .tx_overflow(tx_overflow),
    .busy(busy), .spi_start(spi_start), .spi_width_16(spi_width_16),
    .spi_data_tx(spi_data_tx), .spi_busy(spi_busy), .spi_data_rx(spi_data_rx)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Engine response: transmitted word XOR 0xFF99, truncated to the low byte for 8-bit frames.
  function automatic logic [15:0] echo(input logic [15:0] d, input logic w);
    logic [15:0] x;
    x = d ^ 16'hFF99;
    return w ? x : {8'h00, x[7:0]};
  endfunction

  // Engine model and launch monitor, acting just after each rising edge.
  logic        eng_en, eng_hold, start_prev;
  int          eng_len, eng_left, n_launch;
  logic [15:0] eng_tx;
  logic [16:0] launch_q[$];
  logic [15:0] exp_rx[$];

  initial begin
    spi_busy = 1'b0; spi_data_rx = '0; start_prev = 1'b0;
    eng_left = 0; n_launch = 0; eng_tx = '0;
    forever begin
      @(posedge raw_clk); #1;
      if (spi_start && !start_prev) begin
        launch_q.push_back({spi_width_16, spi_data_tx});
        n_launch++;
      end
      start_prev = spi_start;
      if (spi_busy) begin
        if (eng_left > 0) eng_left--;
        if (eng_left == 0 && !eng_hold) begin
          spi_busy    = 1'b0;
          spi_data_rx = eng_tx ^ 16'hFF99;
        end
      end else if (spi_start && eng_en) begin
        spi_busy = 1'b1;
        eng_tx   = spi_data_tx;
        eng_left = eng_len;
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic w);
    tx_data = d; tx_width_16 = w; tx_push = 1'b1;
    @(negedge raw_clk);
    tx_push = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic w);
    if (rx_enable) exp_rx.push_back(echo(d, w));
    push(d, w);
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    check(name, rx_data, exp);
    rx_pop = 1'b1;
    @(negedge raw_clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || spi_busy) && k < 500) begin
      @(negedge raw_clk);
      k++;
    end
    check({name, "_idle_timeout"}, k < 500, 1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_rx.size() > 0 && k < 2000) begin
      if (!rx_empty) pop_check({name, "_rx"}, exp_rx.pop_front());
      else @(negedge raw_clk);
      k++;
    end
    check({name, "_drained"}, exp_rx.size(), 0);
    wait_idle(name);
    check({name, "_rx_empty"}, rx_empty, 1);
    check({name, "_rx_count"}, rx_count, 0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        w16;
    logic        en;
    logic [15:0] exp_rx;
    logic [4:0]  exp_cnt;
  } vec_t;
  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, k, n, acc;
    logic en;
    logic [16:0] frames[$];
    logic [15:0] d;
    logic w;

    vt[0] = '{16'h00A5, 1'b0, 1'b1, 16'h003C, 5'd1};
    vt[1] = '{16'h1234, 1'b1, 1'b1, 16'hEDAD, 5'd1};
    vt[2] = '{16'hBEEF, 1'b0, 1'b1, 16'h0076, 5'd1};
    vt[3] = '{16'h5A5A, 1'b1, 1'b0, 16'h0000, 5'd0};
    vt[4] = '{16'hFFFF, 1'b1, 1'b1, 16'h0066, 5'd1};
    vt[5] = '{16'h0000, 1'b0, 1'b1, 16'h0099, 5'd1};

    reset = 1'b1; tx_data = '0; tx_width_16 = 1'b0; tx_push = 1'b0;
    rx_enable = 1'b1; rx_pop = 1'b0; clear_flags = 1'b0;
    eng_en = 1'b1; eng_hold = 1'b0; eng_len = 3;
    repeat (3) @(negedge raw_clk);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_flags", {tx_empty, rx_empty, tx_full, rx_full}, 4'b1100);
    check("rst_overflow", tx_overflow, 0);
    check("rst_start", {spi_start, spi_width_16, busy}, 0);
    check("rst_data", {spi_data_tx, rx_data}, 0);
    reset = 1'b0;
    @(negedge raw_clk);

    // Cycle-accurate single 8-bit frame with the engine stalled first.
    eng_en = 1'b0;
    push(16'h00A5, 1'b0);
    check("t1_tx_empty", tx_empty, 0);
    check("t1_no_start_yet", spi_start, 0);
    @(negedge raw_clk);
    check("t1_start", spi_start, 1);
    check("t1_data_tx", {spi_width_16, spi_data_tx}, 17'h000A5);
    repeat (3) @(negedge raw_clk);
    check("t1_start_held", spi_start, 1);
    check("t1_tx_held", tx_count, 1);
    eng_en = 1'b1;
    k = 0;
    while (!spi_busy && k < 50) begin @(negedge raw_clk); k++; end
    check("t1_busy_rise", spi_busy, 1);
    check("t1_start_before_ack", spi_start, 1);
    @(negedge raw_clk);
    check("t1_start_drop", spi_start, 0);
    check("t1_tx_pop", tx_count, 0);
    k = 0;
    while (spi_busy && k < 50) begin @(negedge raw_clk); k++; end
    check("t1_busy_fall", spi_busy, 0);
    @(negedge raw_clk);
    check("t1_capture_not_yet", rx_empty, 1);
    @(negedge raw_clk);
    check("t1_rx_written", {rx_empty, rx_count}, 6'd1);
    check("t1_rx_data", rx_data, 16'h003C);
    check("t1_idle", busy, 0);
    pop_check("t1_pop", 16'h003C);
    check("t1_rx_empty", {rx_empty, rx_data}, 17'h10000);

    // Frame table.
    for (int i = 0; i < 6; i++) begin
      rx_enable = vt[i].en;
      launch_q.delete();
      push(vt[i].data, vt[i].w16);
      @(negedge raw_clk);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_launches", i), launch_q.size(), 1);
      if (launch_q.size() > 0)
        check($sformatf("vec%0d_launch", i), launch_q[0], {vt[i].w16, vt[i].data});
      check($sformatf("vec%0d_rx_count", i), rx_count, vt[i].exp_cnt);
      check($sformatf("vec%0d_rx_data", i), rx_data, vt[i].exp_rx);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vt[i].exp_cnt != 0) pop_check($sformatf("vec%0d_pop", i), vt[i].exp_rx);
    end
    rx_enable = 1'b1;

    // Burst to full, overflow behaviour, then in-order launches.
    eng_en = 1'b0;
    launch_q.delete();
    for (int i = 0; i < DEPTH; i++) send(16'h1000 + 16'(i), 1'b1);
    check("burst_full", {tx_full, tx_count}, {1'b1, 5'(DEPTH)});
    check("burst_no_ovf", tx_overflow, 0);
    push(16'h1008, 1'b1);
    check("burst_ovf", tx_overflow, 1);
    check("burst_dropped", tx_count, DEPTH);
    clear_flags = 1'b1; @(negedge raw_clk); clear_flags = 1'b0;
    check("burst_clear", tx_overflow, 0);
    clear_flags = 1'b1; push(16'h1009, 1'b1); clear_flags = 1'b0;
    check("burst_ovf_beats_clear", tx_overflow, 1);
    clear_flags = 1'b1; @(negedge raw_clk); clear_flags = 1'b0;
    eng_en = 1'b1;
    wait_idle("burst");
    check("burst_launches", launch_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < launch_q.size(); i++)
      check($sformatf("burst_launch%0d", i), launch_q[i], {1'b1, 16'h1000 + 16'(i)});
    check("burst_rx_full", {rx_full, rx_count}, {1'b1, 5'(DEPTH)});
    drain("burst");

    // RX backpressure.
    for (int i = 0; i < DEPTH; i++) send(16'h2000 + 16'(i), 1'b1);
    k = 0;
    while (!rx_full && k < 500) begin @(negedge raw_clk); k++; end
    check("bp_rx_full", rx_full, 1);
    send(16'h2100, 1'b0);
    send(16'h2101, 1'b1);
    base = n_launch;
    repeat (20) @(negedge raw_clk);
    check("bp_no_launch", n_launch, base);
    check("bp_start_low", spi_start, 0);
    check("bp_tx_held", tx_count, 2);
    pop_check("bp_pop", exp_rx.pop_front());
    k = 0;
    while (!rx_full && k < 200) begin @(negedge raw_clk); k++; end
    repeat (20) @(negedge raw_clk);
    check("bp_one_launch", n_launch, base + 1);
    check("bp_tx_left", tx_count, 1);
    check("bp_rx_full_again", rx_full, 1);
    drain("bp");

    // Capture and pop in the same cycle.
    send(16'h0101, 1'b1);
    @(negedge raw_clk);
    wait_idle("sim_a");
    send(16'h0202, 1'b1);
    k = 0;
    while (!spi_busy && k < 50) begin @(negedge raw_clk); k++; end
    k = 0;
    while (spi_busy && k < 50) begin @(negedge raw_clk); k++; end
    @(negedge raw_clk);
    pop_check("sim_head_a", exp_rx.pop_front());
    check("sim_count_kept", rx_count, 1);
    check("sim_head_advanced", rx_data, echo(16'h0202, 1'b1));
    drain("sim");

    // Reset while the engine is mid-transfer.
    send(16'h0303, 1'b1);
    @(negedge raw_clk);
    wait_idle("rr_pre");
    eng_hold = 1'b1;
    push(16'h0404, 1'b1);
    k = 0;
    while (!(spi_busy && !spi_start) && k < 50) begin @(negedge raw_clk); k++; end
    check("rr_in_run", {spi_busy, spi_start}, 2'b10);
    reset = 1'b1; @(negedge raw_clk); reset = 1'b0;
    exp_rx.delete();
    check("rr_counts", {tx_count, rx_count}, 0);
    check("rr_flags", {tx_empty, rx_empty, spi_start, busy}, 4'b1100);
    check("rr_data", {spi_data_tx, rx_data}, 0);
    base = n_launch;
    send(16'h0C0D, 1'b1);
    repeat (10) @(negedge raw_clk);
    check("rr_no_launch", n_launch, base);
    check("rr_start_low", spi_start, 0);
    check("rr_tx_held", tx_count, 1);
    eng_hold = 1'b0;
    wait_idle("rr");
    check("rr_one_launch", n_launch, base + 1);
    check("rr_rx_one", rx_count, 1);
    drain("rr");

    // Random bursts against a queue model.
    for (int r = 0; r < 12; r++) begin
      en = 1'($urandom_range(0, 1));
      n = $urandom_range(1, DEPTH + 2);
      rx_enable = en;
      eng_en = 1'b0;
      launch_q.delete();
      frames.delete();
      for (int i = 0; i < n; i++) begin
        d = 16'($urandom);
        w = 1'($urandom_range(0, 1));
        if (frames.size() < DEPTH) begin
          frames.push_back({w, d});
          if (en) exp_rx.push_back(echo(d, w));
        end
        push(d, w);
      end
      acc = frames.size();
      check($sformatf("rnd%0d_tx_count", r), tx_count, acc);
      check($sformatf("rnd%0d_ovf", r), tx_overflow, n > DEPTH);
      clear_flags = 1'b1; @(negedge raw_clk); clear_flags = 1'b0;
      check($sformatf("rnd%0d_clear", r), tx_overflow, 0);
      eng_len = $urandom_range(1, 5);
      eng_en = 1'b1;
      wait_idle($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_launches", r), launch_q.size(), acc);
      for (int i = 0; i < acc && i < launch_q.size(); i++)
        check($sformatf("rnd%0d_launch%0d", r, i), launch_q[i], frames[i]);
      check($sformatf("rnd%0d_rx_count", r), rx_count, en ? acc : 0);
      check($sformatf("rnd%0d_tx_empty", r), tx_empty, 1);
      drain($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_queue.md
# spi_queue

Buffered front end for the SPI engine, sitting between the peripherals register block and the `spi` instance. CPU writes queue 8- or 16-bit frames into a TX FIFO. A launch state machine hands the frames one at a time to the engine using its start/busy handshake. Received frames are captured into an RX FIFO, so software can issue bursts without polling busy between bytes.

## Interface
- `DEPTH`, default 8: entries per FIFO; power of two, 2..16.
- `raw_clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  16  frame to queue; 8-bit frames use [7:0].
- `tx_width_16`  in  1  frame width, stored with the entry (1 = 16-bit).
- `tx_push`  in  1  one-cycle strobe that enqueues `tx_data`/`tx_width_16`.
- `rx_enable`  in  1  sampled at launch; 0 means the received frame is discarded.
- `rx_pop`  in  1  one-cycle strobe that removes the RX head.
- `clear_flags`  in  1  clears `tx_overflow`.
- `rx_data`  out  16  RX head; 0 when empty.
- `tx_count`, `rx_count`  out  5 each  occupancy, 0..DEPTH.
- `tx_full`, `tx_empty`, `rx_full`, `rx_empty`  out  1 each  occupancy flags.
- `tx_overflow`  out  1  sticky; set when a push is dropped.
- `busy`  out  1  high when the FSM is not in IDLE or the TX FIFO is not empty.
- `spi_start`  out  1  to engine `start`.
- `spi_width_16`  out  1  to engine `width_16`.
- `spi_data_tx`  out  16  to engine `data_tx`.
- `spi_busy`  in  1  from engine `busy`.
- `spi_data_rx`  in  16  from engine `data_rx`.

## Operation
- Reset values:
  - counts 0; `tx_empty`/`rx_empty` 1; `tx_full`/`rx_full` 0.
  - `tx_overflow` 0, `spi_start` 0, `spi_width_16` 0, `spi_data_tx` 0, `rx_data` 0.
  - FSM in IDLE; both FIFOs emptied; pointers 0.
- FIFOs are circular buffers with log2(DEPTH)-bit pointers that wrap from DEPTH-1 to 0. Each count is a separate register.
- TX push:
  - Accepted iff registered `tx_count` < DEPTH.
  - When full, the push is dropped and `tx_overflow` is set, even if the FSM pops the same cycle.
- `clear_flags` and an overflowing push in the same cycle: the flag stays set.
- RX pop when empty is ignored. RX push and pop in the same cycle: both occur and `rx_count` is unchanged.
- FSM states:
  - IDLE: leave when `!tx_empty && !rx_full && !spi_busy`. Go to START; latch the head data/width into `spi_data_tx`/`spi_width_16`; latch `rx_enable` into `keep`.
  - START: `spi_start`=1. When `spi_busy`=1, pop the TX head, drive `spi_start`=0, go to RUN. There is no timeout; START holds while busy stays 0.
  - RUN: when `spi_busy`=0, go to CAPTURE.
  - CAPTURE: if `keep`, push into RX. The value is `spi_data_rx` when 16-bit, or {8'h00, `spi_data_rx`[7:0]} when 8-bit. Return to IDLE.
- Only one frame is ever in flight. Because IDLE requires `!rx_full`, the capture always has room.
- `spi_data_tx` and `spi_width_16` stay stable from START entry until the next launch.

## Timing
- All outputs are registered.
- `rx_data` reflects the new head the cycle after any push or pop.
- Push at edge N (FIFO empty, FSM idle, engine idle):
  - `tx_empty`=0 after edge N.
  - FSM enters START at edge N+1; `spi_start`=1 in cycle N+1.
- Engine raises `spi_busy` at edge S: at edge S+1 the FSM enters RUN, `spi_start` drops, and `tx_count` decrements.
- Engine drops `spi_busy` at edge E:
  - CAPTURE at E+1.
  - RX write and `rx_empty`=0 at E+2.
  - IDLE at E+2.
  - Next launch (`spi_start`=1) no earlier than cycle E+3.
- Reset mid-transfer: everything returns to reset values at that edge. No new launch occurs until the engine's `spi_busy` falls. The in-flight result is never captured.

## Test plan
- Single 8-bit frame: push 0x00A5 width 0, engine model echoes 0xFF3C.
  - `spi_start` pulses until busy, `spi_data_tx`=0x00A5.
  - `rx_data`=0x003C, `rx_count`=1.
  - Then `rx_pop` gives `rx_empty`=1.
- Burst: push DEPTH frames 0x1000..0x1007, 16-bit, with `tx_push` on DEPTH consecutive cycles.
  - `tx_full`=1 once all DEPTH are queued.
  - A 9th push sets `tx_overflow` and is dropped.
  - Exactly DEPTH `spi_start` pulses occur, in order.
  - RX holds the echoes in order.
- RX backpressure: fill RX to DEPTH with TX still holding 2 frames.
  - No `spi_start` while `rx_full`.
  - One `rx_pop` leads to exactly one launch.
- Discard: `rx_enable`=0 at launch; the transfer completes, `rx_count` is unchanged, `busy` returns to 0.
- Simultaneous events: RX push (CAPTURE) and `rx_pop` in the same cycle keep `rx_count` unchanged with the head advanced. `clear_flags` together with an overflowing push leaves `tx_overflow`=1.
- Reset in RUN:
  - Pulse `reset` while `spi_busy`=1: counts 0, `spi_start`=0.
  - Push one frame with busy still high: no launch until busy falls.
  - No stale RX entry appears.
